wbu_commit: RTL

- Write-back/commit stage, directly downstream of the execute stage; consumes its result (wd) and branch decision (PCAsrc/PCBsrc) over the EXU_valid/WBU_ready handshake.
- Owns the 32x32 GPR file, with two combinational read ports feeding decode, and the architectural PC.
- Computes the next PC, commits the GPR write, then offers the new PC to fetch over a WBU_valid/IFU_ready handshake.
- Counts retired instructions.

---
 rtl/wbu_commit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wbu_commit.sv
// Write-back/commit stage: owns the GPR file and architectural PC, retires one
// instruction per EXU handshake and hands the next PC to fetch.
module wbu_commit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EXU_valid,
    output logic             WBU_ready,
    input  logic [31:0]      wd,
    input  logic [4:0]       rd,
    input  logic             regwr,
    input  logic [31:0]      src1,
    input  logic [31:0]      imm,
    input  logic             PCAsrc,
    input  logic             PCBsrc,
    input  logic             ebreak,
    output logic             WBU_valid,
    input  logic             IFU_ready,
    output logic [31:0]      pc,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata1,
    output logic [31:0]      rdata2,
    output logic             commit,
    output logic             halt,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_HANDOFF
    } state_t;

    state_t            r_state;
    logic [31:0]       r_gpr [32];
    logic [31:0]       r_pc;
    logic [31:0]       r_next_pc;
    logic [31:0]       r_wd;
    logic [4:0]        r_rd;
    logic              r_regwr;
    logic              r_ebreak;
    logic              r_commit;
    logic              r_wbu_valid;
    logic              r_halt;
    logic [CNT_W-1:0]  r_retired;

    logic [31:0]       w_base;
    logic [31:0]       w_offset;
    logic [31:0]       w_sum;
    logic [31:0]       w_next_pc;
    logic              w_ready;
    logic              w_accept;

    assign w_ready   = (r_state == S_IDLE) && !r_halt;
    assign w_accept  = EXU_valid && w_ready;

    assign w_base    = PCBsrc ? src1 : r_pc;
    assign w_offset  = PCAsrc ? imm : 32'd4;
    assign w_sum     = w_base + w_offset;
    // Register-relative targets (JALR) always land on an even address.
    assign w_next_pc = {w_sum[31:1], w_sum[0] & ~PCBsrc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_next_pc   <= '0;
            r_wd        <= '0;
            r_rd        <= '0;
            r_regwr     <= 1'b0;
            r_ebreak    <= 1'b0;
            r_commit    <= 1'b0;
            r_wbu_valid <= 1'b0;
            r_halt      <= 1'b0;
            r_retired   <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_commit <= 1'b0;
                    if (w_accept) begin
                        r_wd      <= wd;
                        r_rd      <= rd;
                        r_regwr   <= regwr;
                        r_ebreak  <= ebreak;
                        r_next_pc <= w_next_pc;
                        r_commit  <= 1'b1;
                        r_state   <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_commit <= 1'b0;
                    if (r_regwr && (r_rd != 5'd0)) begin
                        r_gpr[r_rd] <= r_wd;
                    end
                    r_pc        <= r_next_pc;
                    r_retired   <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_ebreak) begin
                        r_halt <= 1'b1;
                    end
                    r_wbu_valid <= 1'b1;
                    r_state     <= S_HANDOFF;
                end
                S_HANDOFF: begin
                    r_commit <= 1'b0;
                    if (IFU_ready) begin
                        r_wbu_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_commit    <= 1'b0;
                    r_wbu_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata1    = (raddr1 == 5'd0) ? '0 : r_gpr[raddr1];
    assign rdata2    = (raddr2 == 5'd0) ? '0 : r_gpr[raddr2];

    assign WBU_ready = w_ready;
    assign WBU_valid = r_wbu_valid;
    assign pc        = r_pc;
    assign commit    = r_commit;
    assign halt      = r_halt;
    assign retired   = r_retired;

endmodule
